// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
package mem_ctrl_pkg;

    // Request opcodes as presented on req_op; 6 and 7 are reserved and answered with an error.
    typedef enum logic [2:0] {
        OP_LB   = 3'd0,
        OP_LNL  = 3'd1,
        OP_LNH  = 3'd2,
        OP_SB   = 3'd3,
        OP_SNL  = 3'd4,
        OP_SNH  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // Controller FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // mem_sel encodings; the value 3 is never driven.
    localparam logic [1:0] SEL_BYTE = 2'd0;
    localparam logic [1:0] SEL_LO   = 2'd1;
    localparam logic [1:0] SEL_HI   = 2'd2;

    // Replace one nibble of the old byte with wdata[3:0].
    function automatic logic [7:0] nibble_merge(input logic [7:0] old,
                                                input logic [7:0] wdata,
                                                input logic       hi);
        return hi ? {wdata[3:0], old[3:0]} : {old[7:4], wdata[3:0]};
    endfunction

    function automatic logic op_is_load(input op_e op);
        return (op == OP_LB) || (op == OP_LNL) || (op == OP_LNH);
    endfunction

    function automatic logic op_is_rsv(input op_e op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

    // The memory always returns the whole byte; nibble loads are extracted and
    // zero-extended here.
    function automatic logic [7:0] load_extract(input logic [7:0] rdata, input op_e op);
        logic [7:0] res;
        case (op)
            OP_LNL:  res = {4'h0, rdata[3:0]};
            OP_LNH:  res = {4'h0, rdata[7:4]};
            default: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundles for the core-side request/response handshake and the memory-side bus.

// Core-side handshake: the core is master, the controller is slave.
interface mem_req_if #(parameter int ADDR_W = 8);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              resp_valid;
    logic [7:0]        resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// Memory-side bus: the controller is master, the data memory is slave.
interface mem_bus_if #(parameter int ADDR_W = 8);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [1:0]        mem_sel;
    logic              mem_write;
    logic              mem_read;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_sel, mem_write, mem_read,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_sel, mem_write, mem_read,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator for the 8-bit data memory: one load/store at a time, nibble stores
// as read-modify-write, saturating counters of completed loads and stores.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_req_if.slave         req,
    mem_bus_if.master        bus,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        data_q, data_d;
    op_e               op_q, op_d;
    logic              err_q, err_d;
    logic              accept;
    logic [1:0]        cnt_inc;

    // A request is taken only while idle.
    assign accept = (state_q == ST_IDLE) && req.req_valid;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            op_q    <= OP_LB;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    case (op_e'(req.req_op))
                        OP_LB, OP_LNL, OP_LNH: state_d = ST_RD;
                        OP_SB:                 state_d = ST_WR;
                        OP_SNL, OP_SNH:        state_d = ST_RMW_RD;
                        default:               state_d = ST_RESP;
                    endcase
                end
            end
            ST_RD:     state_d = ST_RESP;
            ST_WR:     state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Latch request fields on accept and capture read data at the end of each read state.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        op_d    = op_q;
        err_d   = err_q;
        if (accept) begin
            addr_d  = req.req_addr;
            wdata_d = req.req_wdata;
            op_d    = op_e'(req.req_op);
            err_d   = op_is_rsv(op_e'(req.req_op));
            data_d  = '0;
        end
        case (state_q)
            ST_RD:     data_d = load_extract(bus.mem_rdata, op_q);
            ST_RMW_RD: data_d = bus.mem_rdata;
            default:   ;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        req.req_ready  = (state_q == ST_IDLE);
        req.resp_valid = (state_q == ST_RESP);
        req.resp_err   = (state_q == ST_RESP) && err_q;
        req.resp_data  = '0;
        if ((state_q == ST_RESP) && !err_q && op_is_load(op_q)) begin
            req.resp_data = data_q;
        end

        bus.mem_addr  = (state_q == ST_IDLE) ? '0 : addr_q;
        bus.mem_wdata = '0;
        bus.mem_sel   = SEL_BYTE;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        case (state_q)
            ST_RD: begin
                bus.mem_read = 1'b1;
                case (op_q)
                    OP_LNL:  bus.mem_sel = SEL_LO;
                    OP_LNH:  bus.mem_sel = SEL_HI;
                    default: bus.mem_sel = SEL_BYTE;
                endcase
            end
            ST_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = wdata_q;
            end
            ST_RMW_RD: begin
                bus.mem_read = 1'b1;
            end
            ST_RMW_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = nibble_merge(data_q, wdata_q, op_q == OP_SNH);
            end
            default: ;
        endcase
    end

    // Index 0 counts loads, index 1 counts stores; errors count as neither.
    always_comb begin
        cnt_inc    = 2'b00;
        cnt_inc[0] = (state_q == ST_RESP) && !err_q && op_is_load(op_q);
        cnt_inc[1] = (state_q == ST_RESP) && !err_q && !op_is_load(op_q);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Saturating increment: holds at all-ones instead of wrapping.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign ld_cnt = g_cnt[0].cnt_q;
    assign st_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic checked against
// an array-based reference memory; a second instance with 2-bit counters checks saturation.
module tb_mem_access_ctrl;

    logic clk;
    logic reset;
    logic [15:0] ld_cnt_a, st_cnt_a;
    logic [1:0]  ld_cnt_b, st_cnt_b;

    mem_req_if #(.ADDR_W(8)) req_a();
    mem_bus_if #(.ADDR_W(8)) bus_a();
    mem_req_if #(.ADDR_W(8)) req_b();
    mem_bus_if #(.ADDR_W(8)) bus_b();

    mem_access_ctrl #(.ADDR_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .req(req_a), .bus(bus_a),
        .ld_cnt(ld_cnt_a), .st_cnt(st_cnt_a)
    );

    mem_access_ctrl #(.ADDR_W(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .req(req_b), .bus(bus_b),
        .ld_cnt(ld_cnt_b), .st_cnt(st_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    function automatic logic [7:0] init_byte(input int i);
        int v;
        v = i * 37 + 11;
        return v[7:0];
    endfunction

    // Behavioural memories: write at rising edge, read data updated on falling edge.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    bit init_done_a = 1'b0;
    bit init_done_b = 1'b0;

    always @(posedge clk) begin
        if (!init_done_a) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_byte(i);
            init_done_a <= 1'b1;
        end else if (bus_a.mem_write) begin
            case (bus_a.mem_sel)
                2'd1:    mem_a[bus_a.mem_addr] <= {mem_a[bus_a.mem_addr][7:4], bus_a.mem_wdata[3:0]};
                2'd2:    mem_a[bus_a.mem_addr] <= {bus_a.mem_wdata[3:0], mem_a[bus_a.mem_addr][3:0]};
                default: mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
            endcase
        end
    end
    always @(negedge clk) if (bus_a.mem_read) bus_a.mem_rdata <= mem_a[bus_a.mem_addr];

    always @(posedge clk) begin
        if (!init_done_b) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_byte(i);
            init_done_b <= 1'b1;
        end else if (bus_b.mem_write) begin
            mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        end
    end
    always @(negedge clk) if (bus_b.mem_read) bus_b.mem_rdata <= mem_b[bus_b.mem_addr];

    // Bus monitors: strobe counts, accept count, protocol rule violations.
    int wr_cnt_a = 0;
    int rd_cnt_a = 0;
    int acc_b = 0;
    int viol = 0;
    always @(posedge clk) begin
        if (bus_a.mem_write) wr_cnt_a <= wr_cnt_a + 1;
        if (bus_a.mem_read)  rd_cnt_a <= rd_cnt_a + 1;
        if (req_b.req_valid && req_b.req_ready) acc_b <= acc_b + 1;
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_a.mem_read && bus_a.mem_write) viol <= viol + 1;
            else if (bus_a.mem_sel == 2'd3) viol <= viol + 1;
            else if (req_a.req_ready && bus_a.mem_addr != 8'h00) viol <= viol + 1;
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [256];
    int unsigned m_ld = 0;
    int unsigned m_st = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One request on instance A, checked against the reference model.
    task automatic do_txn(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wd);
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         lat;
        int         n;
        int         wr0, rd0;
        exp_data = 8'h00;
        exp_err  = 1'b0;
        case (op)
            3'd0: begin exp_data = ref_mem[addr];        exp_lat = 2; end
            3'd1: begin exp_data = ref_mem[addr] % 16;   exp_lat = 2; end
            3'd2: begin exp_data = ref_mem[addr] / 16;   exp_lat = 2; end
            3'd3: begin ref_mem[addr] = wd;              exp_lat = 2; end
            3'd4: begin ref_mem[addr] = (ref_mem[addr] & 8'hF0) | (wd & 8'h0F); exp_lat = 3; end
            3'd5: begin ref_mem[addr] = ((wd & 8'h0F) << 4) | (ref_mem[addr] & 8'h0F); exp_lat = 3; end
            default: begin exp_err = 1'b1; exp_lat = 1; end
        endcase
        if (!exp_err) begin
            if (op <= 3'd2) begin if (m_ld != 32'hFFFF) m_ld++; end
            else begin if (m_st != 32'hFFFF) m_st++; end
        end

        req_a.req_valid = 1'b1;
        req_a.req_op    = op;
        req_a.req_addr  = addr;
        req_a.req_wdata = wd;
        n = 0;
        while (!req_a.req_ready && n < 20) begin step(); n++; end
        check_val("ready_wait", req_a.req_ready, 1);
        wr0 = wr_cnt_a;
        rd0 = rd_cnt_a;
        step();
        req_a.req_valid = 1'b0;
        lat = 1;
        while (!req_a.resp_valid && lat < 10) begin step(); lat++; end
        check_val("resp_seen", req_a.resp_valid, 1);
        check_val("latency", lat, exp_lat);
        check_val("resp_data", req_a.resp_data, exp_data);
        check_val("resp_err", req_a.resp_err, exp_err);
        $display("txn op=%0d addr=0x%02h wdata=0x%02h resp=0x%02h err=%0d lat=%0d",
                 op, addr, wd, req_a.resp_data, req_a.resp_err, lat);
        step();
        check_val("resp_pulse", req_a.resp_valid, 0);
        check_val("ld_cnt", ld_cnt_a, m_ld);
        check_val("st_cnt", st_cnt_a, m_st);
        if (exp_err) begin
            check_val("err_no_write", wr_cnt_a, wr0);
            check_val("err_no_read", rd_cnt_a, rd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         wrs;
        int         n;
        int         prev_t;
        logic [7:0] mism;
        reset = 1'b1;
        req_a.req_valid = 1'b0; req_a.req_op = 3'd0; req_a.req_addr = 8'h00; req_a.req_wdata = 8'h00;
        req_b.req_valid = 1'b0; req_b.req_op = 3'd0; req_b.req_addr = 8'h00; req_b.req_wdata = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

        // Reset state.
        repeat (2) step();
        check_val("rst_ready", req_a.req_ready, 1);
        check_val("rst_resp_valid", req_a.resp_valid, 0);
        check_val("rst_mem_write", bus_a.mem_write, 0);
        check_val("rst_mem_read", bus_a.mem_read, 0);
        check_val("rst_mem_addr", bus_a.mem_addr, 0);
        check_val("rst_ld_cnt", ld_cnt_a, 0);
        check_val("rst_st_cnt", st_cnt_a, 0);
        reset = 1'b0;
        step();

        // Byte store then load back.
        do_txn(3'd3, 8'h10, 8'hA5);
        do_txn(3'd0, 8'h10, 8'h00);
        check_val("sb_lb_mem", mem_a[8'h10], 8'hA5);
        check_val("sb_lb_ld_cnt", ld_cnt_a, 1);
        check_val("sb_lb_st_cnt", st_cnt_a, 1);

        // High-nibble store, then both nibble loads.
        do_txn(3'd5, 8'h10, 8'h03);
        check_val("snh_mem", mem_a[8'h10], 8'h35);
        do_txn(3'd1, 8'h10, 8'h00);
        do_txn(3'd2, 8'h10, 8'h00);

        // Reserved opcode.
        do_txn(3'd7, 8'h44, 8'h12);
        do_txn(3'd6, 8'h45, 8'h34);

        // Random traffic over a small address window to get read-after-write hits.
        for (int t = 0; t < 60; t++) begin
            do_txn(3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 8'($urandom));
        end

        // Reset while a nibble store is in its read phase.
        req_a.req_valid = 1'b1;
        req_a.req_op    = 3'd4;
        req_a.req_addr  = 8'h20;
        req_a.req_wdata = 8'h0C;
        n = 0;
        while (!req_a.req_ready && n < 20) begin step(); n++; end
        step();
        req_a.req_valid = 1'b0;
        check_val("rmw_rd_active", bus_a.mem_read, 1);
        wrs = wr_cnt_a;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_ld = 0;
        m_st = 0;
        check_val("rst_mid_ready", req_a.req_ready, 1);
        check_val("rst_mid_resp", req_a.resp_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("rst_mid_no_resp", req_a.resp_valid, 0);
        end
        check_val("rst_mid_no_write", wr_cnt_a, wrs);
        check_val("rst_mid_mem", mem_a[8'h20], ref_mem[8'h20]);
        check_val("rst_mid_ld_cnt", ld_cnt_a, 0);
        check_val("rst_mid_st_cnt", st_cnt_a, 0);
        do_txn(3'd0, 8'h20, 8'h00);

        // Whole-memory and bus-rule checks for instance A.
        mism = 8'h00;
        for (int i = 0; i < 256; i++) if (mem_a[i] !== ref_mem[i]) mism++;
        check_val("mem_image", mism, 0);
        check_val("bus_rules", viol, 0);

        // Saturating 2-bit counter with req_valid held high.
        req_b.req_valid = 1'b1;
        req_b.req_op    = 3'd0;
        req_b.req_addr  = 8'h33;
        prev_t = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!req_b.resp_valid && n < 12) begin step(); n++; end
            check_val("sat_resp_seen", req_b.resp_valid, 1);
            if (i > 0) check_val("sat_gap", cyc - prev_t, 3);
            prev_t = cyc;
            if (i == 4) req_b.req_valid = 1'b0;
            check_val("sat_resp_data", req_b.resp_data, init_byte(8'h33));
            step();
            check_val("sat_ld_cnt", ld_cnt_b, (i + 1 > 3) ? 3 : i + 1);
            $display("txn sat idx=%0d resp=0x%02h ld_cnt=%0d", i, req_b.resp_data, ld_cnt_b);
        end
        repeat (3) step();
        check_val("sat_accepts", acc_b, 5);
        check_val("sat_st_cnt", st_cnt_b, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
